// File: rtl/risc_pkg.sv
// Shared opcode and phase definitions for the instruction register, ALU and controller.
package risc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Decoded control bundle driven by the controller.
    typedef struct packed {
        logic sel;
        logic rd;
        logic ldir;
        logic incpc;
        logic ldpc;
        logic ldac;
        logic wr;
        logic datae;
        logic halt;
    } ctrl_t;

    // Opcodes that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Purely combinational phase/opcode to control-line decode.
import risc_pkg::*;

module ctrl_dec (
    input  phase_t  i_phase,
    input  logic    i_halted,
    input  opcode_t i_opcd,
    input  logic    i_zero,
    input  logic    i_ena,
    output ctrl_t   o_ctrl
);

    logic w_alu;

    assign w_alu = is_aluop(i_opcd);

    // Per-phase control decode; strobes are suppressed while ena is low.
    always_comb begin
        o_ctrl = '0;
        if (i_halted) begin
            o_ctrl.halt = 1'b1;
        end else begin
            unique case (i_phase)
                INST_ADDR: begin
                    o_ctrl.sel = 1'b1;
                end
                INST_FETCH: begin
                    o_ctrl.sel = 1'b1;
                    o_ctrl.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    o_ctrl.sel  = 1'b1;
                    o_ctrl.rd   = 1'b1;
                    o_ctrl.ldir = 1'b1;
                end
                OP_ADDR: begin
                    o_ctrl.incpc = 1'b1;
                    o_ctrl.halt  = (i_opcd == HLT);
                end
                OP_FETCH: begin
                    o_ctrl.rd = w_alu;
                end
                ALU_OP: begin
                    o_ctrl.rd    = w_alu;
                    o_ctrl.incpc = (i_opcd == SKZ) && i_zero;
                    o_ctrl.ldpc  = (i_opcd == JMP);
                    o_ctrl.datae = (i_opcd == STO);
                end
                STORE: begin
                    o_ctrl.rd    = w_alu;
                    o_ctrl.ldac  = w_alu;
                    o_ctrl.incpc = (i_opcd == JMP);
                    o_ctrl.ldpc  = (i_opcd == JMP);
                    o_ctrl.wr    = (i_opcd == STO);
                    o_ctrl.datae = (i_opcd == STO);
                end
                default: o_ctrl = '0;
            endcase
            if (!i_ena) begin
                o_ctrl.ldir  = 1'b0;
                o_ctrl.incpc = 1'b0;
                o_ctrl.ldpc  = 1'b0;
                o_ctrl.ldac  = 1'b0;
                o_ctrl.wr    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/controller.sv
// Eight-phase instruction sequencer: owns the phase and sticky halt registers.
import risc_pkg::*;

module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcd,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ldir,
    output logic       incpc,
    output logic       ldpc,
    output logic       ldac,
    output logic       wr,
    output logic       datae,
    output logic       halt,
    output logic [2:0] phase
);

    phase_t  r_phase;
    logic    r_halt;
    phase_t  w_phase_nxt;
    logic    w_halt_nxt;
    opcode_t w_opcd;
    ctrl_t   w_ctrl;

    assign w_opcd = opcode_t'(opcd);

    // Phase and halt state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= INST_ADDR;
            r_halt  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    // Next phase: advance on enable; a HLT in OP_ADDR freezes the phase there.
    always_comb begin
        w_phase_nxt = r_phase;
        w_halt_nxt  = r_halt;
        if (ena && !r_halt) begin
            if ((r_phase == OP_ADDR) && (w_opcd == HLT)) begin
                w_halt_nxt = 1'b1;
            end else begin
                w_phase_nxt = phase_t'(r_phase + 3'd1);
            end
        end
    end

    ctrl_dec u_dec (
        .i_phase  (r_phase),
        .i_halted (r_halt),
        .i_opcd   (w_opcd),
        .i_zero   (zero),
        .i_ena    (ena),
        .o_ctrl   (w_ctrl)
    );

    assign sel   = w_ctrl.sel;
    assign rd    = w_ctrl.rd;
    assign ldir  = w_ctrl.ldir;
    assign incpc = w_ctrl.incpc;
    assign ldpc  = w_ctrl.ldpc;
    assign ldac  = w_ctrl.ldac;
    assign wr    = w_ctrl.wr;
    assign datae = w_ctrl.datae;
    assign halt  = w_ctrl.halt;
    assign phase = r_phase;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: behavioural model plus literal per-instruction masks.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcd;
    logic       zero;
    logic       sel, rd, ldir, incpc, ldpc, ldac, wr, datae, halt;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int m_phase = 0;
    bit m_halt  = 1'b0;

    controller dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .opcd  (opcd),
        .zero  (zero),
        .sel   (sel),
        .rd    (rd),
        .ldir  (ldir),
        .incpc (incpc),
        .ldpc  (ldpc),
        .ldac  (ldac),
        .wr    (wr),
        .datae (datae),
        .halt  (halt),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Expected {sel,rd,ldir,incpc,ldpc,ldac,wr,datae} from the instruction-level rules.
    function automatic logic [7:0] model_out(input int ph, input bit hlt, input logic [2:0] op,
                                             input logic z, input logic en);
        bit alu, sto, jmp, skz;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_dat;
        alu = (op >= 3'd2) && (op <= 3'd5);
        sto = (op == 3'd6);
        jmp = (op == 3'd7);
        skz = (op == 3'd1);
        if (hlt) return 8'h00;
        e_sel  = (ph < 4);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ldir = (ph == 2) || (ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && skz && z) || (ph == 7 && jmp);
        e_ldpc = jmp && (ph >= 6);
        e_ldac = alu && (ph == 7);
        e_wr   = sto && (ph == 7);
        e_dat  = sto && (ph >= 6);
        if (!en) begin
            e_ldir = 0; e_inc = 0; e_ldpc = 0; e_ldac = 0; e_wr = 0;
        end
        return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_dat};
    endfunction

    // Model phase/halt tracking
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_halt  <= 1'b0;
        end else if (ena && !m_halt) begin
            if (m_phase == 4 && opcd == 3'd0) m_halt <= 1'b1;
            else                              m_phase <= (m_phase + 1) % 8;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [7:0] exp_v, act_v;
        string names [8];
        bit exp_h;
        names = '{"datae", "wr", "ldac", "ldpc", "incpc", "ldir", "rd", "sel"};
        exp_v = model_out(m_phase, m_halt, opcd, zero, ena);
        act_v = {sel, rd, ldir, incpc, ldpc, ldac, wr, datae};
        for (int i = 0; i < 8; i++)
            check($sformatf("cmp.%s ph%0d", names[i], m_phase), {7'd0, act_v[i]}, {7'd0, exp_v[i]});
        exp_h = m_halt || (m_phase == 4 && opcd == 3'd0);
        check("cmp.halt", {7'd0, halt}, {7'd0, exp_h});
        check("cmp.phase", {5'd0, phase}, m_phase[7:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from phase 0 and checks per-phase bit masks (bit p = phase p).
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [7:0] x_rd, input logic [7:0] x_ldir,
                             input logic [7:0] x_inc, input logic [7:0] x_ldpc,
                             input logic [7:0] x_ldac, input logic [7:0] x_wr,
                             input logic [7:0] x_dat);
        logic [7:0] c_rd, c_ldir, c_inc, c_ldpc, c_ldac, c_wr, c_dat;
        opcd = op;
        zero = z;
        ena  = 1'b1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            c_rd[p] = rd; c_ldir[p] = ldir; c_inc[p] = incpc; c_ldpc[p] = ldpc;
            c_ldac[p] = ldac; c_wr[p] = wr; c_dat[p] = datae;
            tick();
        end
        check({tag, ".rd"},    c_rd,   x_rd);
        check({tag, ".ldir"},  c_ldir, x_ldir);
        check({tag, ".incpc"}, c_inc,  x_inc);
        check({tag, ".ldpc"},  c_ldpc, x_ldpc);
        check({tag, ".ldac"},  c_ldac, x_ldac);
        check({tag, ".wr"},    c_wr,   x_wr);
        check({tag, ".datae"}, c_dat,  x_dat);
    endtask

    initial begin
        rst  = 1'b1;
        ena  = 1'b0;
        opcd = 3'd2;
        zero = 1'b0;
        @(negedge clk);
        check("rst.phase", {5'd0, phase}, 8'd0);
        check("rst.sel",   {7'd0, sel},   8'd1);
        check("rst.rd",    {7'd0, rd},    8'd0);
        check("rst.halt",  {7'd0, halt},  8'd0);
        tick();
        rst = 1'b0;

        //                  rd           ldir         incpc        ldpc         ldac         wr           datae
        run_instr("ADD",  3'd2, 1'b0, 8'b11101110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b10000000, 8'b00000000, 8'b00000000);
        run_instr("XOR",  3'd4, 1'b1, 8'b11101110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b10000000, 8'b00000000, 8'b00000000);
        run_instr("STO",  3'd6, 1'b0, 8'b00001110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b00000000, 8'b10000000, 8'b11000000);
        run_instr("JMP",  3'd7, 1'b0, 8'b00001110, 8'b00001100, 8'b10010000, 8'b11000000, 8'b00000000, 8'b00000000, 8'b00000000);
        run_instr("SKZ1", 3'd1, 1'b1, 8'b00001110, 8'b00001100, 8'b01010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000);
        run_instr("SKZ0", 3'd1, 1'b0, 8'b00001110, 8'b00001100, 8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000);

        // Reset in the middle of phase 5
        opcd = 3'd2;
        for (int i = 0; i < 5; i++) tick();
        check("mid.phase5", {5'd0, phase}, 8'd5);
        #2 rst = 1'b1;
        #1;
        check("mid.rst.phase", {5'd0, phase}, 8'd0);
        check("mid.rst.sel",   {7'd0, sel},   8'd1);
        check("mid.rst.halt",  {7'd0, halt},  8'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid.rel.phase1", {5'd0, phase}, 8'd1);
        for (int i = 0; i < 7; i++) tick();

        // Enable gating at phase 4
        for (int i = 0; i < 4; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gate.phase", {5'd0, phase}, 8'd4);
            check("gate.incpc", {7'd0, incpc}, 8'd0);
            tick();
        end
        ena = 1'b1;
        @(negedge clk);
        check("gate.incpc.on", {7'd0, incpc}, 8'd1);
        tick();
        check("gate.phase5", {5'd0, phase}, 8'd5);
        @(negedge clk);
        check("gate.incpc.off", {7'd0, incpc}, 8'd0);
        for (int i = 0; i < 3; i++) tick();

        // Mixed traffic: opcode/zero/ena vary every cycle, model does the checking
        for (int i = 0; i < 64; i++) begin
            opcd = 3'($urandom_range(1, 7));
            zero = 1'($urandom_range(0, 1));
            ena  = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Halt and recovery through reset
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        ena  = 1'b1;
        opcd = 3'd2;
        for (int i = 0; i < 4; i++) tick();
        opcd = 3'd0;
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hlt.halt",  {7'd0, halt},  8'd1);
            check("hlt.phase", {5'd0, phase}, 8'd4);
            check("hlt.incpc", {7'd0, incpc}, 8'd0);
            tick();
        end
        rst = 1'b1;
        #1;
        check("hlt.rst.halt",  {7'd0, halt},  8'd0);
        check("hlt.rst.phase", {5'd0, phase}, 8'd0);
        tick();
        rst = 1'b0;
        opcd = 3'd2;
        tick();
        check("hlt.after.phase1", {5'd0, phase}, 8'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  phase-advance enable; 0 holds the current phase.
REQ-005 opcd  input  3  opcode from the instruction register; sampled from phase 4 onward.
REQ-006 zero  input  1  accumulator-is-zero flag.
REQ-007 sel  output  1  address mux select: 1 = PC, 0 = IR address field.
REQ-008 rd  output  1  memory read enable.
REQ-009 ldir  output  1  load strobe to the instruction register.
REQ-010 incpc  output  1  PC increment strobe.
REQ-011 ldpc  output  1  PC load strobe (jump).
REQ-012 ldac  output  1  accumulator load strobe.
REQ-013 wr  output  1  memory write strobe.
REQ-014 datae  output  1  data-bus drive enable (store).
REQ-015 halt  output  1  processor halted, sticky.
REQ-016 phase  output  3  current phase, 0..7.

Function
REQ-017 The phase register SHALL be 3 bits and advance by 1 on each clk edge with ena=1 and halt=0, wrapping from 7 to 0.
REQ-018 Opcode encoding SHALL be 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; ALUOP SHALL mean ADD, AND, XOR or LDA.
REQ-019 Outputs SHALL be a combinational decode of the phase, halt, opcd, zero and ena signals, with zero added latency.
REQ-020 Phase 0 (instruction address) SHALL drive sel=1 and all other decoded outputs 0.
REQ-021 Phase 1 (instruction fetch) SHALL drive sel=1 and rd=1.
REQ-022 Phases 2 and 3 (instruction load and idle) SHALL drive sel=1, rd=1 and ldir=1.
REQ-023 Phase 4 (operand address) SHALL drive incpc=1, plus halt=1 when opcd=HLT.
REQ-024 Phase 5 (operand fetch) SHALL drive rd=ALUOP.
REQ-025 Phase 6 (ALU) SHALL drive the following:
- rd=ALUOP;
- incpc=(SKZ and zero);
- ldpc=JMP;
- datae=STO.
REQ-026 Phase 7 (store) SHALL drive the following:
- rd=ALUOP;
- ldac=ALUOP;
- incpc=JMP;
- ldpc=JMP;
- wr=STO;
- datae=STO.
REQ-027 Strobes (ldir, incpc, ldpc, ldac, wr) SHALL be forced to 0 while ena=0; level outputs (sel, rd, datae, phase, halt) SHALL keep their decoded values.
REQ-028 The halt register SHALL set on the clk edge that ends phase 4 when opcd=HLT and ena=1.
REQ-029 The halt register SHALL then hold phase at 4 and force all outputs except halt and phase to 0.
REQ-030 Halt SHALL clear only on reset.
REQ-031 An instruction SHALL take exactly 8 enabled cycles.
REQ-032 When opcd is SKZ and zero=1, the instruction SHALL produce two incpc pulses (phases 4 and 6).
REQ-033 When opcd is JMP, ldpc SHALL be high in phases 6 and 7, and incpc SHALL be high in phases 4 and 7.
REQ-034 When opcd changes mid-instruction, the decode SHALL follow the current opcd without latching it; stability from phase 4 through phase 7 is the upstream contract.

Reset
REQ-035 While rst=1, the block SHALL hold phase=0 and halt=0, independent of clk.
REQ-036 During reset the outputs SHALL be sel=1 and all others 0.
REQ-037 Reset asserted mid-instruction SHALL abort the instruction immediately; after release the first enabled edge SHALL move to phase 1.
REQ-038 Reset release SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-039 A shared package risc_pkg SHALL hold the 3-bit opcode constants (HLT..JMP) and the phase constants (INST_ADDR=0 .. STORE=7), for use by the instruction register, ALU and controller.
REQ-040 One sub-module, ctrl_dec, SHALL hold the purely combinational phase/opcode-to-control decode; the controller top SHALL own the phase and halt registers.

Verification
REQ-041 Reset: rst=1 mid-phase 5, then release with ena=1 -> phase=0 and sel=1 immediately; phase=1 after the first edge; halt=0.
REQ-042 ADD: opcd=2 over 8 cycles ->
- rd=1 in phases 1,2,3,5,6,7;
- ldir=1 in phases 2,3;
- incpc=1 in phase 4 only;
- ldac=1 in phase 7 only;
- wr=0 throughout.
REQ-043 STO/JMP: opcd=6 -> datae=1 in phases 6,7 and wr=1 in phase 7 only; opcd=7 -> ldpc=1 in phases 6,7 and incpc=1 in phases 4,7.
REQ-044 SKZ: opcd=1 with zero=1 -> incpc=1 in phases 4 and 6; with zero=0 -> incpc=1 in phase 4 only.
REQ-045 HLT: opcd=0 at phase 4 -> halt=1 and phase stuck at 4 for 20 cycles with incpc=0; rst=1 -> halt=0 and phase=0.
REQ-046 ena gating: ena=0 for 3 cycles in phase 4 -> phase stays 4 and incpc=0; ena=1 -> incpc=1 for exactly one cycle, then phase=5.
